// File: rtl/signal_shaper_pkg.sv
// signal_shaper_pkg: shared types and constants for the four-channel signal shaper.
package signal_shaper_pkg;

  localparam int unsigned N_CH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } ch_state_e;

  // Register offsets relative to BASE_ADDR
  localparam logic [7:0] OFF_ENABLE    = 8'd0;
  localparam logic [7:0] OFF_PULSE_LEN = 8'd1;
  localparam logic [7:0] OFF_DEAD_TIME = 8'd2;
  localparam logic [7:0] OFF_CLEAR     = 8'd3;
  localparam logic [7:0] OFF_LOSS      = 8'd4;
  localparam logic [7:0] N_LOSS_REGS   = 8'd8;

  // Register reset defaults
  localparam logic [3:0] ENABLE_RST    = 4'hF;
  localparam logic [7:0] PULSE_LEN_RST = 8'd2;
  localparam logic [7:0] DEAD_TIME_RST = 8'd4;

endpackage

// File: rtl/signal_shaper_ch.sv
// signal_shaper_ch: one channel -- synchroniser, rising-edge detect, IDLE/PULSE/DEAD
// shaping FSM with a down-counter, and an optional saturating lost-edge counter
// (built when SIGNAL_SHAPER_LOSS_CNT_EN is defined).
module signal_shaper_ch
  import signal_shaper_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         raw,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] pulse_len,
  input  logic [W-1:0] dead_time,
  output logic         pulse,
  output logic [15:0]  loss
);

  logic         sync1, sync2, sync3;
  logic         rise;
  ch_state_e    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_d;
  logic         reject;

  // Two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // State, down-counter and registered pulse output
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  // Next-state: lengths are sampled only on state entry, so mid-state writes wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PULSE;
            cnt_d   = (pulse_len == '0) ? W'(1) : pulse_len;
          end
        end
        PULSE: begin
          if (cnt_q <= W'(1)) begin
            if (dead_time == '0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = DEAD;
              cnt_d   = dead_time;
            end
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        DEAD: begin
          if (cnt_q <= W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: pulse follows PULSE one cycle later; busy-state edges are losses
  always_comb begin
    pulse_d = (state_q == PULSE) && en;
    reject  = rise && en && (state_q != IDLE);
  end

`ifdef SIGNAL_SHAPER_LOSS_CNT_EN
  // Saturating lost-edge counter; a clear in the same cycle as a loss wins
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      loss <= '0;
    end else if (clr) begin
      loss <= '0;
    end else if (reject && (loss != 16'hFFFF)) begin
      loss <= loss + 16'd1;
    end
  end
`else
  assign loss = '0;
  logic unused_loss_inputs;
  assign unused_loss_inputs = &{1'b0, clr, reject};
`endif

endmodule

// File: rtl/signal_shaper.sv
// signal_shaper: four-channel input conditioner ahead of the pulse counter.
// Holds the register decode and read mux; per-channel shaping is in signal_shaper_ch.
// Define SIGNAL_SHAPER_LOSS_CNT_EN to build the lost-edge counters and clear register.
module signal_shaper
  import signal_shaper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [7:0]  BASE_ADDR  = 8'h40
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [7:0]            addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [N_CH-1:0]       raw_in,
  output logic [N_CH-1:0]       pulse_out
);

  logic [N_CH-1:0]       enable;
  logic [DATA_WIDTH-1:0] pulse_len;
  logic [DATA_WIDTH-1:0] dead_time;
  logic [N_CH-1:0]       clr;
  logic [15:0]           loss [N_CH];
  logic [7:0]            off;
  logic [2:0]            lsel;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  assign off = addr - BASE_ADDR;

  // Configuration registers; loss and clear offsets are not stored here
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      enable    <= ENABLE_RST;
      pulse_len <= DATA_WIDTH'(PULSE_LEN_RST);
      dead_time <= DATA_WIDTH'(DEAD_TIME_RST);
    end else if (we) begin
      case (off)
        OFF_ENABLE:    enable    <= data_in[N_CH-1:0];
        OFF_PULSE_LEN: pulse_len <= data_in;
        OFF_DEAD_TIME: dead_time <= data_in;
        default: ;
      endcase
    end
  end

  // Clear strobes act on the same edge as the write
  always_comb begin
    clr = '0;
    if (we && (off == OFF_CLEAR)) clr = data_in[N_CH-1:0];
  end

  // Read mux: loss registers are low byte then high byte, channel 0 first
  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    lsel    = 3'(off - OFF_LOSS);
    if (off == OFF_ENABLE) begin
      rd_data = DATA_WIDTH'(enable);
    end else if (off == OFF_PULSE_LEN) begin
      rd_data = pulse_len;
    end else if (off == OFF_DEAD_TIME) begin
      rd_data = dead_time;
    end else if (off == OFF_CLEAR) begin
      rd_data = '0;
    end else if ((off >= OFF_LOSS) && (off < OFF_LOSS + N_LOSS_REGS)) begin
      rd_data = lsel[0] ? DATA_WIDTH'(loss[lsel[2:1]][15:8])
                        : DATA_WIDTH'(loss[lsel[2:1]][7:0]);
    end else begin
      rd_hit = 1'b0;
    end
  end

  // Registered read data; unmapped addresses hold the previous value
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_out <= '0;
    end else if (rd_hit) begin
      data_out <= rd_data;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    signal_shaper_ch #(
      .W (DATA_WIDTH)
    ) u_ch (
      .clk       (clk),
      .res_n     (res_n),
      .raw       (raw_in[i]),
      .en        (enable[i]),
      .clr       (clr[i]),
      .pulse_len (pulse_len),
      .dead_time (dead_time),
      .pulse     (pulse_out[i]),
      .loss      (loss[i])
    );
  end

endmodule

// File: tb/tb_signal_shaper.sv
// tb_signal_shaper: directed, self-checking bench for signal_shaper.
module tb_signal_shaper;

`ifdef SIGNAL_SHAPER_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;
  logic [3:0] raw_in;
  logic [3:0] pulse_out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  d;
  logic [15:0] v;
  int          hi;
  logic [3:0]  exp_p;

  signal_shaper #(
    .DATA_WIDTH (8),
    .BASE_ADDR  (8'h40)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .addr      (addr),
    .data_in   (data_in),
    .we        (we),
    .data_out  (data_out),
    .raw_in    (raw_in),
    .pulse_out (pulse_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] dat);
    addr    = a;
    data_in = dat;
    we      = 1'b1;
    step(1);
    we      = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] dat);
    addr = a;
    step(1);
    dat = data_out;
  endtask

  task automatic rd_loss(input int ch, output logic [15:0] val);
    logic [7:0] lo, hb;
    rd(8'(8'h44 + 2 * ch), lo);
    rd(8'(8'h45 + 2 * ch), hb);
    val = {hb, lo};
  endtask

  initial begin
    res_n = 1'b0; raw_in = '0; addr = '0; data_in = '0; we = 1'b0;
    step(3);
    chk("rst_pulse", 16'(pulse_out), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    res_n = 1'b1;
    step(2);

    // Register defaults and unmapped-read hold
    rd(8'h40, d); chk("def_enable", 16'(d), 16'h0F);
    rd(8'h41, d); chk("def_pulse_len", 16'(d), 16'h02);
    rd(8'h43, d); chk("def_clear_reads0", 16'(d), 16'h00);
    rd(8'h42, d); chk("def_dead_time", 16'(d), 16'h04);
    rd(8'h4C, d); chk("unmapped_hi_hold", 16'(d), 16'h04);
    rd(8'h3F, d); chk("unmapped_lo_hold", 16'(d), 16'h04);

    // Single rise on ch0: 3-cycle latency, 2-cycle pulse
    raw_in[0] = 1'b1;
    step(3); chk("t1_latency_low", 16'(pulse_out), 16'h0);
    step(1); chk("t1_pulse_c1", 16'(pulse_out), 16'h1);
    step(1); chk("t1_pulse_c2", 16'(pulse_out), 16'h1);
    step(1); chk("t1_pulse_end", 16'(pulse_out), 16'h0);
    raw_in[0] = 1'b0;
    step(10);

    // pulse_len=0 (acts as 1), dead_time=0, rises every 2 cycles on ch1
    wr(8'h41, 8'd0);
    wr(8'h42, 8'd0);
    step(2);
    for (int i = 0; i < 12; i++) begin
      raw_in[1] = (i < 8) && (i % 2 == 0);
      step(1);
      exp_p = ((i + 1) >= 4 && (i + 1) <= 10 && ((i + 1) % 2 == 0)) ? 4'b0010 : 4'b0000;
      chk("t2_pulse_train", 16'(pulse_out), 16'(exp_p));
    end
    rd_loss(1, v); chk("t2_loss1", v, 16'h0);
    wr(8'h41, 8'd2);
    wr(8'h42, 8'd4);
    step(4);

    // Three rises on ch2 in quick succession: one pulse, two losses
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      raw_in[2] = (i < 6) && (i % 2 == 0);
      step(1);
      if (pulse_out[2]) hi++;
    end
    chk("t3_pulse_cycles", 16'(hi), 16'd2);
    rd_loss(2, v); chk("t3_loss2", v, LOSS_EN ? 16'h0002 : 16'h0000);
    wr(8'h43, 8'h04);
    rd_loss(2, v); chk("t3_loss2_cleared", v, 16'h0);
    wr(8'h44, 8'hAA);
    rd_loss(0, v); chk("t3_loss_write_ignored", v, 16'h0);

    // ch3: edge in the last DEAD cycle is rejected
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    step(5);
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pulse_out[3]) hi++;
    end
    chk("t4_reject_at_expiry", 16'(hi), 16'd0);
    step(4);

    // ch3: edge in the first IDLE cycle after DEAD is accepted
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    step(6);
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    step(2); chk("t4_accept_pre", 16'(pulse_out), 16'h0);
    step(1); chk("t4_accept_c1", 16'(pulse_out), 16'h8);
    step(1); chk("t4_accept_c2", 16'(pulse_out), 16'h8);
    step(1); chk("t4_accept_end", 16'(pulse_out), 16'h0);
    step(8);
    rd_loss(3, v); chk("t4_loss3", v, LOSS_EN ? 16'h0001 : 16'h0000);

    // ch3: clear on the same edge as a rejected-edge increment
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    step(1);
    raw_in[3] = 1'b1; step(1); raw_in[3] = 1'b0;
    step(1);
    wr(8'h43, 8'h08);
    step(10);
    rd_loss(3, v); chk("t4_clear_wins", v, 16'h0);

    // ch0 disabled mid-PULSE (pulse_len=4)
    wr(8'h41, 8'd4);
    step(2);
    raw_in[0] = 1'b1; step(1); raw_in[0] = 1'b0;
    step(3); chk("t5_pulse_on", 16'(pulse_out), 16'h1);
    wr(8'h40, 8'h0E);
    chk("t5_pulse_still_on", 16'(pulse_out), 16'h1);
    step(1); chk("t5_forced_low", 16'(pulse_out), 16'h0);
    step(1); chk("t5_stays_low", 16'(pulse_out), 16'h0);
    step(2);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      raw_in[0] = (i < 6) && (i % 2 == 0);
      step(1);
      if (pulse_out[0]) hi++;
    end
    chk("t5_disabled_no_pulse", 16'(hi), 16'd0);
    rd_loss(0, v); chk("t5_disabled_no_loss", v, 16'h0);

    // Reset asserted mid-DEAD on ch1 (pulse_len=2, dead_time=10)
    wr(8'h40, 8'h0F);
    wr(8'h41, 8'd2);
    wr(8'h42, 8'd10);
    step(2);
    raw_in[1] = 1'b1; step(1); raw_in[1] = 1'b0;
    step(6);
    rd(8'h42, d); chk("t6_pre_dead_time", 16'(d), 16'h0A);
    #2;
    res_n = 1'b0;
    #1;
    chk("t6_async_pulse", 16'(pulse_out), 16'h0);
    chk("t6_async_data", 16'(data_out), 16'h0);
    step(2);
    res_n = 1'b1;
    step(1);
    rd(8'h42, d); chk("t6_dead_time_default", 16'(d), 16'h04);
    rd(8'h40, d); chk("t6_enable_default", 16'(d), 16'h0F);
    raw_in[1] = 1'b1; step(1); raw_in[1] = 1'b0;
    step(2); chk("t6_after_rst_pre", 16'(pulse_out), 16'h0);
    step(1); chk("t6_after_rst_pulse", 16'(pulse_out), 16'h2);
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
